// File: rtl/imm_decode_stage.sv
// RV32I immediate decode stage: decodes format/immediate at push and buffers
// decoded entries in a 2-deep FIFO whose head drives the registered outputs.
module imm_decode_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm,
    output logic [31:0] out_pc,
    output logic [2:0]  out_ext_sel,
    output logic        out_illegal,
    output logic [7:0]  illegal_cnt
);

    localparam logic [2:0] SEL_I1   = 3'd0;
    localparam logic [2:0] SEL_I2   = 3'd1;
    localparam logic [2:0] SEL_S    = 3'd2;
    localparam logic [2:0] SEL_B    = 3'd3;
    localparam logic [2:0] SEL_U    = 3'd4;
    localparam logic [2:0] SEL_J    = 3'd5;
    localparam logic [2:0] SEL_NONE = 3'd7;

    logic [1:0]  count;
    logic [31:0] tail_imm;
    logic [31:0] tail_pc;
    logic [2:0]  tail_sel;
    logic        tail_illegal;

    logic [2:0]  dec_sel;
    logic        dec_illegal;
    logic [31:0] dec_imm;
    logic        push;
    logic        pop;

    always_comb begin
        dec_sel     = SEL_NONE;
        dec_illegal = 1'b0;
        unique case (in_instr[6:0])
            7'b0010011: dec_sel = (in_instr[13:12] == 2'b01) ? SEL_I2 : SEL_I1;
            7'b0000011,
            7'b1100111: dec_sel = SEL_I1;
            7'b0100011: dec_sel = SEL_S;
            7'b1100011: dec_sel = SEL_B;
            7'b0110111,
            7'b0010111: dec_sel = SEL_U;
            7'b1101111: dec_sel = SEL_J;
            7'b0110011: dec_sel = SEL_NONE;
            default:    dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_imm = '0;
        case (dec_sel)
            SEL_I1: dec_imm = {{20{in_instr[31]}}, in_instr[31:20]};
            SEL_I2: dec_imm = {27'd0, in_instr[24:20]};
            SEL_S:  dec_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            SEL_B:  dec_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
            SEL_U:  dec_imm = {in_instr[31:12], 12'd0};
            SEL_J:  dec_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
            default: dec_imm = '0;
        endcase
    end

    assign in_ready  = !rst && (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= 2'd0;
            out_imm      <= '0;
            out_pc       <= '0;
            out_ext_sel  <= SEL_NONE;
            out_illegal  <= 1'b0;
            tail_imm     <= '0;
            tail_pc      <= '0;
            tail_sel     <= SEL_NONE;
            tail_illegal <= 1'b0;
            illegal_cnt  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            // Head register is the output; the tail slot only fills behind a stalled head.
            if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
                out_imm     <= dec_imm;
                out_pc      <= in_pc;
                out_ext_sel <= dec_sel;
                out_illegal <= dec_illegal;
            end else if (push) begin
                tail_imm     <= dec_imm;
                tail_pc      <= in_pc;
                tail_sel     <= dec_sel;
                tail_illegal <= dec_illegal;
            end else if (pop && count == 2'd2) begin
                out_imm     <= tail_imm;
                out_pc      <= tail_pc;
                out_ext_sel <= tail_sel;
                out_illegal <= tail_illegal;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push && dec_illegal && illegal_cnt != 8'hFF)
                illegal_cnt <= illegal_cnt + 8'd1;
        end
    end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-high reset; the clock is named clk and the reset rst.
REQ-002 Parameter: DEPTH, default 2, output buffer entries; only 2 is supported.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: in_valid  input  1  upstream (IF/ID) holds a valid instruction.
REQ-006 Port: in_instr  input  32  raw RV32I instruction word.
REQ-007 Port: in_pc  input  32  PC of in_instr.
REQ-008 Port: in_ready  output  1  block can accept a word this cycle.
REQ-009 Port: flush  input  1  synchronous kill of all buffered and incoming entries.
REQ-010 Port: out_valid  output  1  head entry valid.
REQ-011 Port: out_ready  input  1  downstream consumes head entry.
REQ-012 Port: out_imm  output  32  extended immediate of head entry.
REQ-013 Port: out_pc  output  32  PC of head entry.
REQ-014 Port: out_ext_sel  output  3  immediate format of head entry.
REQ-015 Port: out_illegal  output  1  head entry opcode not recognised.
REQ-016 Port: illegal_cnt  output  8  saturating count of accepted illegal entries.

Function
REQ-017 ext_sel encoding SHALL be: 0 I_1, 1 I_2, 2 S, 3 B, 4 U, 5 J, 7 NONE; 6 unused.
REQ-018 Decode by opcode[6:0]: 0010011 with funct3 001/101 -> I_2, else I_1; 0000011, 1100111 -> I_1; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0110011 -> NONE; anything else -> NONE with illegal=1.
REQ-019 Immediate: I_1 = sign-extended instr[31:20]; I_2 = zero-extended instr[24:20]; S = sext{instr[31:25],instr[11:7]}; B = sext{instr[31],instr[7],instr[30:25],instr[11:8],0}; U = {instr[31:12],12'b0}; J = sext{instr[31],instr[19:12],instr[20],instr[30:21],0}; NONE = 0.
REQ-020 Immediate, ext_sel and illegal SHALL be computed at push and stored with PC; outputs are driven only from registers.
REQ-021 Buffer: 2-entry FIFO with occupancy count 0..2; in_ready = !rst && count<2.
REQ-022 Push when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
REQ-023 Latency: a word pushed at edge N SHALL be presented on the outputs from cycle N+1 when the buffer was empty.
REQ-024 out_valid = count!=0; head outputs hold stable while out_valid && !out_ready.
REQ-025 Simultaneous push and pop at count 1: count stays 1, the new entry becomes head after the edge.
REQ-026 At count 2, in_ready=0; no push occurs even if pop happens that cycle.
REQ-027 Pop at count 0 SHALL NOT occur; out_ready ignored when out_valid=0.
REQ-028 flush: at the edge count becomes 0, same-cycle input is dropped, illegal_cnt unchanged by the dropped word.
REQ-029 illegal_cnt increments by 1 per pushed illegal entry, saturates at 255, never wraps.
REQ-030 Order preserved: entries leave in push order.

Reset
REQ-031 During rst, in_ready=0; at the edge with rst=1: count=0, out_valid=0, out_imm=0, out_pc=0, out_ext_sel=7, out_illegal=0, illegal_cnt=0.
REQ-032 rst mid-operation discards all entries and dominates flush, push and pop.
REQ-033 First push is possible on the first cycle after rst deasserts.

Verification
REQ-034 Push 0xFFF00093 (addi) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_ext_sel=0.
REQ-035 Push 0x41F0D093 (srai) then 0xFE112E23 (sw) -> out_imm 0x0000001F sel 1, then 0xFFFFFFFC sel 2, in order.
REQ-036 Push 0xFE000EE3 (beq) and 0x12345037 (lui), out_ready=0 -> count 2, in_ready=0, head holds 0xFFFFFFFC sel 3; release -> 0x12345000 sel 4.
REQ-037 Push 300 words of 0x0000007F -> out_illegal=1, out_ext_sel=7, out_imm=0, illegal_cnt saturates at 255.
REQ-038 Buffer full, assert flush together with in_valid -> next cycle out_valid=0, count 0, illegal_cnt unchanged; assert rst while full -> all outputs at reset values.
